prog_memory: RTL and testbench
==============================

PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter OPC_W, default 4, opcode field width.
REQ-003 SHALL have parameter IMM_W, default 4, immediate field width; word width W = OPC_W+IMM_W, stored as {immediate, opcode}.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  in  1  clock, all state on rising edge; rst  in  1  asynchronous reset, active-high.
REQ-005 fetch_addr  in  ADDR_W  CPU fetch address.
REQ-006 opcode_out  out  OPC_W  opcode of word at fetch_addr; immediate_out  out  IMM_W  immediate of same word.
REQ-007 wr_en  in  1  direct single-word write strobe; wr_addr  in  ADDR_W; wr_opc  in  OPC_W; wr_imm  in  IMM_W.
REQ-008 load_start  in  1  begin bulk program load.
REQ-009 ld_valid  in  1, ld_data  in  W ({imm,opc}), ld_ready  out  1  valid/ready stream of program words.
REQ-010 busy  out  1  memory not available to CPU (CPU SHALL stall); load_done  out  1  one-cycle pulse on load completion.
REQ-011 ld_sum  out  W  running checksum of current load (see Configuration).

Function
REQ-012 FSM states CLEAR, IDLE, LOAD, DONE; reset state CLEAR.
REQ-013 CLEAR: writes zero to word clr_ptr each cycle, clr_ptr 0..DEPTH-1; after writing DEPTH-1 -> IDLE; takes exactly DEPTH cycles.
REQ-014 IDLE: load_start=1 -> LOAD next cycle, wr_ptr=0; otherwise stay.
REQ-015 IDLE: wr_en=1 writes {wr_imm,wr_opc} to wr_addr at clock edge; wr_en ignored in every other state.
REQ-016 IDLE with load_start and wr_en both 1: direct write performed and FSM enters LOAD.
REQ-017 LOAD: ld_ready=1; each cycle with ld_valid&ld_ready writes ld_data to wr_ptr, wr_ptr+1.
REQ-018 LOAD: transfer at wr_ptr=DEPTH-1 -> DONE; wr_ptr wraps to 0, no write past last word.
REQ-019 LOAD: load_start=1 restarts: wr_ptr=0, checksum cleared, no word written that cycle even if ld_valid=1 (ld_ready SHALL be 0 that cycle).
REQ-020 DONE: load_done=1 for exactly one cycle, then IDLE; ld_ready=0.
REQ-021 ld_ready=0 in CLEAR, IDLE, DONE.
REQ-022 busy=1 in CLEAR, LOAD, DONE; 0 in IDLE.
REQ-023 Read combinational, zero latency: opcode_out/immediate_out reflect mem[fetch_addr] when busy=0; forced to 0 (NOP) when busy=1.
REQ-024 Write then read same address: new value visible the cycle after the write edge.

Reset
REQ-025 rst=1 SHALL asynchronously force state CLEAR, clr_ptr=0, wr_ptr=0, ld_sum=0, load_done=0, ld_ready=0, busy=1, opcode_out=0, immediate_out=0.
REQ-026 Memory array not reset asynchronously; cleared by CLEAR sequence after rst deasserts.
REQ-027 rst mid-LOAD SHALL abandon load; no load_done pulse; full CLEAR follows.

Configuration
REQ-028 Macro PROG_MEMORY_CHECKSUM_EN defined: ld_sum = modulo-2^W sum of all words accepted in current load, cleared on entry to LOAD, held through DONE/IDLE until next load_start.
REQ-029 Macro not defined: ld_sum tied 0, no checksum logic.

Verification
REQ-030 Release rst, defaults: busy=1 for 16 cycles, then busy=0; every fetch_addr 0..15 reads opcode_out=0, immediate_out=0.
REQ-031 IDLE, wr_en, wr_addr=5, wr_opc=4'hB, wr_imm=4'h3 -> next cycle fetch_addr=5 gives opcode_out=B, immediate_out=3.
REQ-032 load_start then 16 words 8'h00..8'h0F with ld_valid toggling every other cycle -> 16 writes, load_done one cycle after last transfer, addr k reads opc=k, imm=0; ld_sum=8'h78 (CHECKSUM_EN) or 0.
REQ-033 load_start reasserted after 3 words of load -> ld_ready=0 that cycle, next accepted word lands at addr 0, ld_sum restarts.
REQ-034 wr_en during LOAD at addr 2 with 8'hFF -> ignored; addr 2 holds loaded word.
REQ-035 rst pulse after 7 loaded words -> no load_done, busy=1 for 16 cycles, all words read 0.

Source files
------------

// File: rtl/prog_memory.sv
// prog_memory: program store with direct writes, streamed bulk load and post-reset clear.
// Optional load checksum on ld_sum when PROG_MEMORY_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module prog_memory #(
  parameter int ADDR_W = 4,
  parameter int OPC_W  = 4,
  parameter int IMM_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic [OPC_W-1:0]        opcode_out,
  output logic [IMM_W-1:0]        immediate_out,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [OPC_W-1:0]        wr_opc,
  input  logic [IMM_W-1:0]        wr_imm,
  input  logic                    load_start,
  input  logic                    ld_valid,
  input  logic [OPC_W+IMM_W-1:0]  ld_data,
  output logic                    ld_ready,
  output logic                    busy,
  output logic                    load_done,
  output logic [OPC_W+IMM_W-1:0]  ld_sum
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int W = OPC_W + IMM_W;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, wr_ptr, waddr;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wdata;
  logic we, xfer, start;
  always_comb begin
    ld_ready = state == LOAD && !load_start;
    xfer = ld_ready && ld_valid;
    start = load_start && (state == IDLE || state == LOAD);
    busy = state != IDLE;
    load_done = state == DONE;
    state_nx = state;
    we = 1'b0;
    waddr = wr_addr;
    wdata = {wr_imm, wr_opc};
    case (state)
      CLEAR: begin
        we = 1'b1;
        waddr = clr_ptr;
        wdata = '0;
        state_nx = clr_ptr == '1 ? IDLE : CLEAR;
      end
      IDLE: begin
        we = wr_en;
        state_nx = load_start ? LOAD : IDLE;
      end
      LOAD: begin
        we = xfer;
        waddr = wr_ptr;
        wdata = ld_data;
        state_nx = xfer && wr_ptr == '1 ? DONE : LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      clr_ptr <= state == CLEAR ? clr_ptr + 1'b1 : '0;
      wr_ptr <= start ? '0 : xfer ? wr_ptr + 1'b1 : wr_ptr;
    end
  end
  // the array has no reset; the CLEAR sweep zeroes it after every reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign opcode_out = busy ? '0 : mem[fetch_addr][OPC_W-1:0];
  assign immediate_out = busy ? '0 : mem[fetch_addr][W-1:OPC_W];
`ifdef PROG_MEMORY_CHECKSUM_EN
  logic [W-1:0] sum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum <= '0;
    else sum <= start ? '0 : xfer ? sum + ld_data : sum;
  end
  assign ld_sum = sum;
`else
  assign ld_sum = '0;
`endif
endmodule

// File: tb/tb_prog_memory.sv
// tb_prog_memory: directed self-checking bench for prog_memory at default parameters.
`timescale 1ns/1ps
module tb_prog_memory;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] fetch_addr = '0, opcode_out, immediate_out;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0, wr_opc = '0, wr_imm = '0;
  logic load_start = 1'b0, ld_valid = 1'b0, ld_ready, busy, load_done;
  logic [7:0] ld_data = '0, ld_sum;
  int checks = 0, errors = 0;

  prog_memory dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .opcode_out(opcode_out),
    .immediate_out(immediate_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_opc(wr_opc),
    .wr_imm(wr_imm), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .busy(busy), .load_done(load_done), .ld_sum(ld_sum)
  );

  always #5 clk = ~clk;

`ifdef PROG_MEMORY_CHECKSUM_EN
  localparam logic [7:0] SUM_FULL = 8'h78;
`else
  localparam logic [7:0] SUM_FULL = 8'h00;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear();
    int n = 0;
    logic pulsed = 1'b0;
    while (busy && n < 40) begin
      step();
      n++;
      if (load_done) pulsed = 1'b1;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL clear_cycles: got %0d expected 16", n);
    end
    checks++;
    if (pulsed !== 1'b0) begin
      errors++;
      $display("FAIL no_done_in_clear: got load_done pulse expected none");
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      checks++;
      if ({immediate_out, opcode_out} !== 8'h00) begin
        errors++;
        $display("FAIL %s addr %0d: got %h expected 00", tag, a, {immediate_out, opcode_out});
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, ld_ready, load_done, ld_sum, opcode_out, immediate_out} !== {3'b100, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b done=%b sum=%h opc=%h imm=%h expected 1 0 0 00 0 0",
               busy, ld_ready, load_done, ld_sum, opcode_out, immediate_out);
    end
    step();
    step();
    rst = 1'b0;
    wait_clear();
    check_all_zero("reset_read");
  endtask

  task automatic test_direct_write();
    wr_en = 1'b1; wr_addr = 4'd5; wr_opc = 4'hB; wr_imm = 4'h3;
    step();
    wr_en = 1'b0;
    fetch_addr = 4'd5;
    #1;
    checks++;
    if ({immediate_out, opcode_out} !== 8'h3B) begin
      errors++;
      $display("FAIL direct_write: got %h expected 3b", {immediate_out, opcode_out});
    end
  endtask

  task automatic test_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    fetch_addr = 4'd5;
    #1;
    checks++;
    if ({busy, ld_ready, opcode_out, immediate_out} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL load_entry: got busy=%b rdy=%b opc=%h imm=%h expected 1 1 0 0",
               busy, ld_ready, opcode_out, immediate_out);
    end
    for (int k = 0; k < 16; k++) begin
      ld_valid = 1'b0;
      step();
      ld_valid = 1'b1;
      ld_data = 8'(k);
      step();
      ld_valid = 1'b0;
      if (k < 15) begin
        checks++;
        if (load_done !== 1'b0) begin
          errors++;
          $display("FAIL early_done at word %0d: got 1 expected 0", k);
        end
      end
    end
    checks++;
    if ({load_done, ld_ready, busy, ld_sum} !== {3'b101, SUM_FULL}) begin
      errors++;
      $display("FAIL load_done: got done=%b rdy=%b busy=%b sum=%h expected 1 0 1 %h",
               load_done, ld_ready, busy, ld_sum, SUM_FULL);
    end
    step();
    checks++;
    if ({load_done, busy, ld_sum} !== {2'b00, SUM_FULL}) begin
      errors++;
      $display("FAIL after_done: got done=%b busy=%b sum=%h expected 0 0 %h",
               load_done, busy, ld_sum, SUM_FULL);
    end
    for (int a = 0; a < 16; a++) begin
      fetch_addr = 4'(a);
      #1;
      checks++;
      if ({immediate_out, opcode_out} !== 8'(a)) begin
        errors++;
        $display("FAIL load_read addr %0d: got %h expected %h", a, {immediate_out, opcode_out}, 8'(a));
      end
    end
  endtask

  task automatic test_restart();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1'b1;
      ld_data = 8'hA0 + 8'(k);
      step();
    end
    load_start = 1'b1;
    ld_data = 8'hEE;
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_ready: got %b expected 0", ld_ready);
    end
    step();
    load_start = 1'b0;
    checks++;
    if (ld_sum !== 8'h00) begin
      errors++;
      $display("FAIL restart_sum: got %h expected 00", ld_sum);
    end
    for (int k = 0; k < 16; k++) begin
      ld_data = 8'h10 + 8'(k);
      step();
    end
    ld_valid = 1'b0;
    checks++;
    if ({load_done, ld_sum} !== {1'b1, SUM_FULL}) begin
      errors++;
      $display("FAIL restart_done: got done=%b sum=%h expected 1 %h", load_done, ld_sum, SUM_FULL);
    end
    step();
    fetch_addr = 4'd0;
    #1;
    checks++;
    if ({immediate_out, opcode_out} !== 8'h10) begin
      errors++;
      $display("FAIL restart_addr0: got %h expected 10", {immediate_out, opcode_out});
    end
    fetch_addr = 4'd3;
    #1;
    checks++;
    if ({immediate_out, opcode_out} !== 8'h13) begin
      errors++;
      $display("FAIL restart_addr3: got %h expected 13", {immediate_out, opcode_out});
    end
  endtask

  task automatic test_wr_ignored();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd2; wr_opc = 4'hF; wr_imm = 4'hF;
    ld_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ld_data = 8'h20 + 8'(k);
      step();
    end
    ld_valid = 1'b0;
    wr_en = 1'b0;
    step();
    fetch_addr = 4'd2;
    #1;
    checks++;
    if ({immediate_out, opcode_out} !== 8'h22) begin
      errors++;
      $display("FAIL wr_in_load addr2: got %h expected 22", {immediate_out, opcode_out});
    end
  endtask

  task automatic test_rst_mid_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    ld_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      ld_data = 8'h50 + 8'(k);
      step();
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, ld_ready, load_done, ld_sum} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL async_rst: got busy=%b rdy=%b done=%b sum=%h expected 1 0 0 00",
               busy, ld_ready, load_done, ld_sum);
    end
    step();
    rst = 1'b0;
    wait_clear();
    check_all_zero("rst_mid_load_read");
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_load();
    test_restart();
    test_wr_ignored();
    test_rst_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
